// File: rtl/iiitb_cg_pkg.sv
// Shared types and constants for the two-channel clock-gating controller.
// Optional build macro: IIITB_CG_STATS_EN enables the gated-cycle statistics counters.
package iiitb_cg_pkg;

    localparam int CG_CNT_W  = 8;
    localparam int CG_STAT_W = 16;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        WAKE = 2'b01,
        ON   = 2'b10,
        IDLE = 2'b11
    } cg_state_e;

    function automatic logic [CG_STAT_W-1:0] stat_sat_inc(input logic [CG_STAT_W-1:0] value);
        logic [CG_STAT_W-1:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/iiitb_cg_chan.sv
// One clock-gating channel: OFF/WAKE/ON/IDLE FSM with wake and idle counters and flopped en/gnt.
// Optional build macro: IIITB_CG_STATS_EN builds the saturating gated-cycle counter.
module iiitb_cg_chan
    import iiitb_cg_pkg::*;
#(
    parameter int IDLE_CYCLES = 4,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 r,
    output logic                 en,
    output logic                 gnt,
    output logic [CG_STAT_W-1:0] gated_cnt
);

    localparam logic [CG_CNT_W-1:0] WAKE_LAST = CG_CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CG_CNT_W-1:0] IDLE_LAST = CG_CNT_W'(IDLE_CYCLES - 1);

    cg_state_e           state_r;
    cg_state_e           state_nxt_s;
    logic [CG_CNT_W-1:0] wake_cnt_r;
    logic [CG_CNT_W-1:0] wake_cnt_nxt_s;
    logic [CG_CNT_W-1:0] idle_cnt_r;
    logic [CG_CNT_W-1:0] idle_cnt_nxt_s;
    logic                en_r;
    logic                gnt_r;
    logic                en_nxt_s;
    logic                gnt_nxt_s;

    // State, counter and output flops; en/gnt are decoded from next state so they change with the FSM edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= OFF;
            wake_cnt_r <= 8'd0;
            idle_cnt_r <= 8'd0;
            en_r       <= 1'b0;
            gnt_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wake_cnt_r <= wake_cnt_nxt_s;
            idle_cnt_r <= idle_cnt_nxt_s;
            en_r       <= en_nxt_s;
            gnt_r      <= gnt_nxt_s;
        end
    end

    // Next-state and counter update logic
    always_comb begin
        state_nxt_s    = state_r;
        wake_cnt_nxt_s = wake_cnt_r;
        idle_cnt_nxt_s = idle_cnt_r;
        case (state_r)
            OFF: begin
                if (r) begin
                    state_nxt_s    = WAKE;
                    wake_cnt_nxt_s = 8'd0;
                end else begin
                    state_nxt_s    = OFF;
                end
            end
            WAKE: begin
                // Wake always runs to completion; r is not looked at here
                wake_cnt_nxt_s = wake_cnt_r + 8'd1;
                if (wake_cnt_r == WAKE_LAST) begin
                    state_nxt_s = ON;
                end else begin
                    state_nxt_s = WAKE;
                end
            end
            ON: begin
                if (r) begin
                    state_nxt_s    = ON;
                    idle_cnt_nxt_s = 8'd0;
                end else begin
                    state_nxt_s    = IDLE;
                    idle_cnt_nxt_s = 8'd1;
                end
            end
            IDLE: begin
                if (r) begin
                    state_nxt_s    = ON;
                    idle_cnt_nxt_s = 8'd0;
                end else if (idle_cnt_r == IDLE_LAST) begin
                    state_nxt_s    = OFF;
                    idle_cnt_nxt_s = 8'd0;
                end else begin
                    state_nxt_s    = IDLE;
                    idle_cnt_nxt_s = idle_cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s    = OFF;
                wake_cnt_nxt_s = 8'd0;
                idle_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // Output decode from the next state
    always_comb begin
        en_nxt_s  = 1'b0;
        gnt_nxt_s = 1'b0;
        case (state_nxt_s)
            OFF: begin
                en_nxt_s  = 1'b0;
                gnt_nxt_s = 1'b0;
            end
            WAKE: begin
                en_nxt_s  = 1'b1;
                gnt_nxt_s = 1'b0;
            end
            ON, IDLE: begin
                en_nxt_s  = 1'b1;
                gnt_nxt_s = 1'b1;
            end
            default: begin
                en_nxt_s  = 1'b0;
                gnt_nxt_s = 1'b0;
            end
        endcase
    end

    assign en  = en_r;
    assign gnt = gnt_r;

`ifdef IIITB_CG_STATS_EN
    logic [CG_STAT_W-1:0] gated_cnt_r;

    // Count edges where the registered enable is low, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            gated_cnt_r <= 16'h0000;
        end else if (!en_r) begin
            gated_cnt_r <= stat_sat_inc(gated_cnt_r);
        end else begin
            gated_cnt_r <= gated_cnt_r;
        end
    end

    assign gated_cnt = gated_cnt_r;
`else
    assign gated_cnt = 16'h0000;
`endif

endmodule

// File: rtl/iiitb_cg_ctrl.sv
// Two-channel clock-gating controller: per-channel request plus a shared force_on override.
// Optional build macro: IIITB_CG_STATS_EN enables gated_cnt0/gated_cnt1 statistics.
module iiitb_cg_ctrl
    import iiitb_cg_pkg::*;
#(
    parameter int IDLE_CYCLES = 4,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    input  logic                 force_on,
    output logic [1:0]           en,
    output logic [1:0]           gnt,
    output logic [CG_STAT_W-1:0] gated_cnt0,
    output logic [CG_STAT_W-1:0] gated_cnt1
);

    logic [1:0] r_s;

    assign r_s = req | {2{force_on}};

    iiitb_cg_chan #(
        .IDLE_CYCLES(IDLE_CYCLES),
        .WAKE_CYCLES(WAKE_CYCLES)
    ) u_chan0 (
        .clk      (clk),
        .rst      (rst),
        .r        (r_s[0]),
        .en       (en[0]),
        .gnt      (gnt[0]),
        .gated_cnt(gated_cnt0)
    );

    iiitb_cg_chan #(
        .IDLE_CYCLES(IDLE_CYCLES),
        .WAKE_CYCLES(WAKE_CYCLES)
    ) u_chan1 (
        .clk      (clk),
        .rst      (rst),
        .r        (r_s[1]),
        .en       (en[1]),
        .gnt      (gnt[1]),
        .gated_cnt(gated_cnt1)
    );

endmodule

// File: tb/tb_iiitb_cg_ctrl.sv
// Scoreboard bench for iiitb_cg_ctrl: a timestamp-based reference model predicts en/gnt/gated counts.
// Honours IIITB_CG_STATS_EN for the expected gated counter values.
module tb_iiitb_cg_ctrl;

    localparam int IDLE_C = 4;
    localparam int WAKE_C = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic        force_on;
    logic [1:0]  en;
    logic [1:0]  gnt;
    logic [15:0] gated_cnt0;
    logic [15:0] gated_cnt1;

    typedef struct {
        int          edge_no;
        logic [1:0]  en;
        logic [1:0]  gnt;
        logic [15:0] c0;
        logic [15:0] c1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a channel is either off, or on since wake edge start;
    // grant comes WAKE_C edges after start; it turns off IDLE_C edges after its last activity.
    int k = 0;
    bit m_off[2] = '{1'b1, 1'b1};
    int m_start[2] = '{0, 0};
    int m_last[2] = '{0, 0};
    int m_cnt[2] = '{0, 0};

    iiitb_cg_ctrl #(.IDLE_CYCLES(IDLE_C), .WAKE_CYCLES(WAKE_C)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .force_on  (force_on),
        .en        (en),
        .gnt       (gnt),
        .gated_cnt0(gated_cnt0),
        .gated_cnt1(gated_cnt1)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic m_rst, input logic [1:0] m_req, input logic m_f);
        exp_t e;
        k++;
        for (int i = 0; i < 2; i++) begin
            bit r;
            bit en_prev;
            r = m_req[i] | m_f;
            en_prev = !m_off[i];
            if (m_rst) begin
                m_off[i] = 1'b1;
                m_cnt[i] = 0;
            end else begin
                if (!en_prev && m_cnt[i] < 65535) m_cnt[i]++;
                if (m_off[i]) begin
                    if (r) begin
                        m_off[i]   = 1'b0;
                        m_start[i] = k;
                        m_last[i]  = k + WAKE_C;
                    end
                end else if (k > m_start[i] + WAKE_C) begin
                    if (r) m_last[i] = k;
                    else if (k - m_last[i] == IDLE_C) m_off[i] = 1'b1;
                end
            end
        end
        e.edge_no = k;
        for (int i = 0; i < 2; i++) begin
            e.en[i]  = !m_off[i];
            e.gnt[i] = !m_off[i] && (k >= m_start[i] + WAKE_C);
        end
`ifdef IIITB_CG_STATS_EN
        e.c0 = 16'(m_cnt[0]);
        e.c1 = 16'(m_cnt[1]);
`else
        e.c0 = 16'h0000;
        e.c1 = 16'h0000;
`endif
        exp_q.push_back(e);
    endtask

    task automatic step(input logic s_rst, input logic [1:0] s_req, input logic s_f);
        rst      = s_rst;
        req      = s_req;
        force_on = s_f;
        @(posedge clk);
        model_edge(s_rst, s_req, s_f);
        #1;
    endtask

    task automatic chk(input string nm, input int ed, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s edge=%0d actual=%0h expected=%0h", nm, ed, act, expv);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("en", e.edge_no, int'(en), int'(e.en));
            chk("gnt", e.edge_no, int'(gnt), int'(e.gnt));
            chk("gated_cnt0", e.edge_no, int'(gated_cnt0), int'(e.c0));
            chk("gated_cnt1", e.edge_no, int'(gated_cnt1), int'(e.c1));
        end
    end

    initial begin
        // Reset release with both requests high
        for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 2'b11, 1'b0);
        // Idle timeout on channel 0 only
        for (int i = 0; i < 8; i++) step(1'b0, 2'b10, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 2'b11, 1'b0);
        // Idle cancel: three low samples, one high, three low, then high
        for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 1'b0);
        step(1'b0, 2'b11, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 2'b11, 1'b0);
        // Single-cycle pulse on channel 1 from OFF
        for (int i = 0; i < 10; i++) step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b10, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 2'b00, 1'b0);
        // force_on pulse, then force_on followed by reset mid-wake
        step(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        step(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 1'b0);
        // Randomized traffic with occasional force_on and reset
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] rq;
            rq[0] = ($urandom_range(0, 3) == 0);
            rq[1] = ($urandom_range(0, 2) != 0);
            step(($urandom_range(0, 63) == 0), rq, ($urandom_range(0, 15) == 0));
        end
        // Hold channel 0 off long enough to saturate its gated counter
        step(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 65600; i++) begin
            step(1'b0, {1'($urandom_range(0, 7) == 0), 1'b0}, 1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iiitb_cg_ctrl.md
IIITB_CG_CTRL -- requirements
Module: iiitb_cg_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CYCLES, default 4: consecutive idle samples before a channel's clock is gated off; legal range 2..255.
REQ-002 SHALL have parameter WAKE_CYCLES, default 2: cycles between enable rise and grant; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, 2 bits: per-channel activity request, bit0 for channel 0 and bit1 for channel 1.
REQ-006 SHALL have port force_on, input, 1 bit: treated as req=1 on both channels.
REQ-007 SHALL have port en, output, 2 bits: registered per-channel enable that drives the ICG cell enable input.
REQ-008 SHALL have port gnt, output, 2 bits: registered per-channel grant meaning "gated clock running and stable".
REQ-009 SHALL have port gated_cnt0, output, 16 bits: count of cycles in which en[0]=0.
REQ-010 SHALL have port gated_cnt1, output, 16 bits: count of cycles in which en[1]=0.

Function
REQ-011 SHALL run two independent, identical channels; each has its own FSM with states OFF, WAKE, ON and IDLE.
REQ-012 SHALL define the effective request as r = req[i] OR force_on, sampled at each rising edge.
REQ-013 OFF: en=0, gnt=0. If r=1, the FSM goes to WAKE, en=1 after that edge, and the wake counter clears.
REQ-014 WAKE: en=1, gnt=0. The wake counter increments every cycle regardless of r. After WAKE_CYCLES edges spent in WAKE, the FSM goes to ON and gnt=1 after that edge.
REQ-015 An r=1 sample in OFF at edge t SHALL give en=1 after edge t and gnt=1 after edge t+WAKE_CYCLES.
REQ-016 Dropping r during WAKE SHALL NOT abort the wake; the FSM reaches ON, then follows the idle rules.
REQ-017 ON: en=1, gnt=1. If r=0, the FSM goes to IDLE with idle counter = 1; if r=1, it stays in ON.
REQ-018 IDLE: en=1, gnt=1. If r=1, the FSM returns to ON and clears the idle counter. If r=0 and the idle counter is IDLE_CYCLES-1, the FSM goes to OFF with en=0 and gnt=0 after that edge. Otherwise the idle counter increments.
REQ-019 en SHALL fall exactly after the edge that captures the IDLE_CYCLES-th consecutive r=0 sample.
REQ-020 en and gnt SHALL be flop outputs with no combinational path from req or force_on, so the ICG enable stays glitch-free.
REQ-021 Counters SHALL be 8 bits wide and SHALL never wrap within the legal parameter range.
REQ-022 Asserting force_on in any state SHALL keep ON and IDLE channels in ON, and SHALL move OFF channels to WAKE.

Reset
REQ-023 rst=1 at an edge SHALL force both FSMs to OFF, clear all counters, set en=2'b00 and gnt=2'b00, and clear gated_cnt0/1. This holds mid-WAKE and mid-IDLE.
REQ-024 The first edge with rst=0 SHALL evaluate the OFF transitions normally.

Configuration
REQ-025 Macro IIITB_CG_STATS_EN, when defined: gated_cnt<i> increments on each edge where en[i]=0 and rst=0, and saturates at 16'hFFFF.
REQ-026 Without IIITB_CG_STATS_EN: the gated_cnt0/1 ports remain present, are tied to 16'h0000, and no counter flops are built.

Structure
REQ-027 Package iiitb_cg_pkg SHALL hold the FSM state typedef (OFF, WAKE, ON, IDLE), the counter width constant CG_CNT_W=8, and the stats width constant CG_STAT_W=16.
REQ-028 Sub-module iiitb_cg_chan SHALL implement one channel (FSM, wake/idle counters, en/gnt flops, optional stats counter); the top SHALL instantiate it twice.

Verification (IDLE_CYCLES=4, WAKE_CYCLES=2)
REQ-029 Reset release: hold rst=1 for 3 cycles with req=2'b11 -> en=0, gnt=0, gated_cnt0=0; rst=0 at edge 4 -> en=2'b11 after edge 4, gnt=2'b11 after edge 6.
REQ-030 Idle timeout: from ON, drive req[0]=0 from edge 10 -> en[0]=1 through edge 12 and en[0]=0 after edge 13; en[1] is unaffected.
REQ-031 Idle cancel: from ON, drive req[0]=0 for 3 samples and then 1 -> en[0] and gnt[0] stay 1 throughout; a following run of 3 low samples also keeps en[0]=1.
REQ-032 Wake not aborted: in OFF, pulse req[1] high for 1 cycle -> en[1]=1 for 2 WAKE cycles plus 4 IDLE/ON cycles, gnt[1]=1 for 4 cycles, then both return to 0.
REQ-033 force_on: with req=0 and both channels OFF, assert force_on for 1 cycle -> both channels wake and grant with identical timing; a reset mid-WAKE returns en to 0 on the next edge.
REQ-034 Stats (IIITB_CG_STATS_EN defined): hold channel 0 OFF for 70000 cycles -> gated_cnt0 = 16'hFFFF and holds there. Without the macro, gated_cnt0 = 0 throughout.
